// File: rtl/ram_4w1r_lvt_pkg.sv
// Shared types for the 4-write/1-read LVT memory: data width, bank encodings, LVT entry.
// Pure declarations; no latency or backpressure.
package ram_4w1r_lvt_pkg;
    localparam int DW     = 32;
    localparam int NWPORT = 4;
    localparam int LVT_W  = 3;

    typedef enum logic [1:0] {
        BANK_1 = 2'd0,
        BANK_2 = 2'd1,
        BANK_3 = 2'd2,
        BANK_4 = 2'd3
    } bank_e;

    typedef struct packed {
        logic  vld;
        bank_e bank;
    } lvt_t;
endpackage

// File: rtl/ram_4w1r_lvt_if.sv
// Write/read bus of the LVT memory; master drives requests, slave returns read data.
// No handshake: reads always complete one cycle later.
interface ram_4w1r_lvt_if #(parameter int BLOCKSIZE = 10);
    import ram_4w1r_lvt_pkg::*;
    localparam int AW = BLOCKSIZE + 1;

    logic [AW-1:0] w_addr_1, w_addr_2, w_addr_3, w_addr_4;
    logic [DW-1:0] w_din_1, w_din_2, w_din_3, w_din_4;
    logic          w_enb_1, w_enb_2, w_enb_3, w_enb_4;
    logic          r_enb;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_dout;
    logic          r_valid;
    logic          w_conflict;

    modport master (
        output w_addr_1, w_addr_2, w_addr_3, w_addr_4,
        output w_din_1, w_din_2, w_din_3, w_din_4,
        output w_enb_1, w_enb_2, w_enb_3, w_enb_4,
        output r_enb, r_addr,
        input  r_dout, r_valid, w_conflict
    );

    modport slave (
        input  w_addr_1, w_addr_2, w_addr_3, w_addr_4,
        input  w_din_1, w_din_2, w_din_3, w_din_4,
        input  w_enb_1, w_enb_2, w_enb_3, w_enb_4,
        input  r_enb, r_addr,
        output r_dout, r_valid, w_conflict
    );
endinterface

// File: rtl/ram_4w1r_lvt_wbank_1r1w.sv
// One 1R1W bank, read-first: a same-cycle write is not visible to the read.
// Registered read output, 1-cycle latency; output holds when i_renb is low.
module wbank_1r1w
    import ram_4w1r_lvt_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdin,
    input  logic          i_wenb,
    input  logic [AW-1:0] i_raddr,
    input  logic          i_renb,
    output logic [DW-1:0] o_rdat
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdat;

    always_ff @(posedge clk) begin
        if (i_wenb) begin
            r_mem[i_waddr] <= i_wdin;
        end
        if (i_renb) begin
            r_rdat <= r_mem[i_raddr];
        end
    end

    assign o_rdat = r_rdat;
endmodule

// File: rtl/ram_4w1r_lvt.sv
// 4-write/1-read memory: one bank per write port, LVT picks the bank holding the newest value.
// Read latency 1 cycle, one read per cycle; no backpressure.
module ram_4w1r_lvt
    import ram_4w1r_lvt_pkg::*;
#(
    parameter int BLOCKSIZE = 10
) (
    input logic              clk,
    input logic              rst,
    ram_4w1r_lvt_if.slave    bus
);
    localparam int AW    = BLOCKSIZE + 1;
    localparam int DEPTH = 1 << AW;

    logic [AW-1:0] w_addr [NWPORT];
    logic [DW-1:0] w_din  [NWPORT];
    logic          w_enb  [NWPORT];
    logic [DW-1:0] w_bank_dat [NWPORT];
    logic          w_rd_go;
    logic          w_conf_det;

    lvt_t          r_lvt [DEPTH];
    lvt_t          r_rd_lvt;
    logic          r_valid;
    logic          r_conflict;

    assign w_addr[0] = bus.w_addr_1;
    assign w_addr[1] = bus.w_addr_2;
    assign w_addr[2] = bus.w_addr_3;
    assign w_addr[3] = bus.w_addr_4;
    assign w_din[0]  = bus.w_din_1;
    assign w_din[1]  = bus.w_din_2;
    assign w_din[2]  = bus.w_din_3;
    assign w_din[3]  = bus.w_din_4;
    // Writes are suppressed during reset so banks and LVT stay consistent.
    assign w_enb[0]  = bus.w_enb_1 & rst;
    assign w_enb[1]  = bus.w_enb_2 & rst;
    assign w_enb[2]  = bus.w_enb_3 & rst;
    assign w_enb[3]  = bus.w_enb_4 & rst;
    assign w_rd_go   = bus.r_enb & rst;

    for (genvar g = 0; g < NWPORT; g++) begin : g_bank
        wbank_1r1w #(.AW(AW)) u_bank (
            .clk     (clk),
            .i_waddr (w_addr[g]),
            .i_wdin  (w_din[g]),
            .i_wenb  (w_enb[g]),
            .i_raddr (bus.r_addr),
            .i_renb  (w_rd_go),
            .o_rdat  (w_bank_dat[g])
        );
    end

    always_comb begin
        w_conf_det = 1'b0;
        for (int i = 0; i < NWPORT; i++) begin
            for (int j = i + 1; j < NWPORT; j++) begin
                if (w_enb[i] && w_enb[j] && (w_addr[i] == w_addr[j])) begin
                    w_conf_det = 1'b1;
                end
            end
        end
    end

    // Highest port index is applied first so that the lowest-numbered port wins on a tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                r_lvt[a] <= '0;
            end
        end else begin
            for (int p = NWPORT - 1; p >= 0; p--) begin
                if (w_enb[p]) begin
                    r_lvt[w_addr[p]] <= lvt_t'{vld: 1'b1, bank: bank_e'(p[1:0])};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_lvt   <= '0;
            r_valid    <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            if (bus.r_enb) begin
                r_rd_lvt <= r_lvt[bus.r_addr];
            end
            r_valid    <= bus.r_enb;
            r_conflict <= w_conf_det;
        end
    end

    // LVT sample and bank words were captured on the same edge, so select and data agree.
    assign bus.r_dout     = r_rd_lvt.vld ? w_bank_dat[r_rd_lvt.bank] : '0;
    assign bus.r_valid    = r_valid;
    assign bus.w_conflict = r_conflict;
endmodule

// File: tb/tb_ram_4w1r_lvt.sv
// Randomized + directed bench for ram_4w1r_lvt with a scoreboard and an address-level memory model.
module tb_ram_4w1r_lvt;
    import ram_4w1r_lvt_pkg::*;

    localparam int BLOCKSIZE = 10;
    localparam int AW        = BLOCKSIZE + 1;
    localparam int DEPTH     = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_4w1r_lvt_if #(.BLOCKSIZE(BLOCKSIZE)) bus ();

    ram_4w1r_lvt #(.BLOCKSIZE(BLOCKSIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [AW-1:0] wa [4];
    logic [DW-1:0] wd [4];
    logic          we [4];
    logic          ren;
    logic [AW-1:0] ra;

    assign bus.w_addr_1 = wa[0];
    assign bus.w_addr_2 = wa[1];
    assign bus.w_addr_3 = wa[2];
    assign bus.w_addr_4 = wa[3];
    assign bus.w_din_1  = wd[0];
    assign bus.w_din_2  = wd[1];
    assign bus.w_din_3  = wd[2];
    assign bus.w_din_4  = wd[3];
    assign bus.w_enb_1  = we[0];
    assign bus.w_enb_2  = we[1];
    assign bus.w_enb_3  = we[2];
    assign bus.w_enb_4  = we[3];
    assign bus.r_enb    = ren;
    assign bus.r_addr   = ra;

    // Reference: the newest value written to each address, or "never written".
    logic [DW-1:0] ref_val [DEPTH];
    logic          ref_has [DEPTH];
    logic [DW-1:0] ref_dout;

    logic          q_vld [$];
    logic [DW-1:0] q_dat [$];
    logic          q_cf  [$];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic idle();
        for (int p = 0; p < 4; p++) begin
            we[p] = 1'b0;
            wa[p] = '0;
            wd[p] = '0;
        end
        ren = 1'b0;
        ra  = '0;
    endtask

    task automatic wr(input int p, input int addr, input logic [DW-1:0] d);
        we[p] = 1'b1;
        wa[p] = AW'(addr);
        wd[p] = d;
    endtask

    task automatic rd(input int addr);
        ren = 1'b1;
        ra  = AW'(addr);
    endtask

    // Predict this cycle's outcome from the pre-edge model, clock once, then apply writes.
    task automatic cycle();
        logic cf;
        cf = 1'b0;
        if (!rst) begin
            ref_dout = '0;
        end else if (ren) begin
            ref_dout = ref_has[ra] ? ref_val[ra] : '0;
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i != j && rst && we[i] && we[j] && wa[i] == wa[j]) cf = 1'b1;
            end
        end
        q_vld.push_back(rst && ren);
        q_dat.push_back(ref_dout);
        q_cf.push_back(cf);
        @(posedge clk);
        if (!rst) begin
            for (int a = 0; a < DEPTH; a++) ref_has[a] = 1'b0;
        end else begin
            // Port 1 has priority: apply it last.
            for (int p = 3; p >= 0; p--) begin
                if (we[p]) begin
                    ref_val[wa[p]] = wd[p];
                    ref_has[wa[p]] = 1'b1;
                end
            end
        end
        #1;
        idle();
    endtask

    always @(negedge clk) begin
        if (q_vld.size() > 0) begin
            logic          ev;
            logic [DW-1:0] ed;
            logic          ec;
            ev = q_vld.pop_front();
            ed = q_dat.pop_front();
            ec = q_cf.pop_front();
            n_vec++;
            if (bus.r_valid !== ev) begin
                n_miss++;
                $display("FAIL r_valid: got %b expected %b at %0t", bus.r_valid, ev, $time);
            end
            n_vec++;
            if (bus.r_dout !== ed) begin
                n_miss++;
                $display("FAIL r_dout: got %h expected %h at %0t", bus.r_dout, ed, $time);
            end
            n_vec++;
            if (bus.w_conflict !== ec) begin
                n_miss++;
                $display("FAIL w_conflict: got %b expected %b at %0t", bus.w_conflict, ec, $time);
            end
        end
    end

    initial begin
        int drain;
        for (int a = 0; a < DEPTH; a++) begin
            ref_has[a] = 1'b0;
            ref_val[a] = '0;
        end
        ref_dout = '0;
        idle();
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;

        // Read of a never-written address.
        rd(5); cycle();
        // Single write then read-back.
        wr(2, 12, 32'hDEADBEEF); cycle();
        rd(12); cycle();
        // Same-address conflict, port 2 wins.
        wr(1, 7, 32'h22); wr(3, 7, 32'h44); cycle();
        rd(7); cycle();
        // Read-first collision.
        wr(0, 100, 32'h1); cycle();
        wr(3, 100, 32'h4); rd(100); cycle();
        rd(100); cycle();
        // Four distinct writes, then back-to-back reads.
        for (int p = 0; p < 4; p++) wr(p, p, 32'hA0 + p);
        cycle();
        for (int a = 0; a < 4; a++) begin
            rd(a); cycle();
        end
        cycle();
        // Write and read under reset: both dropped.
        wr(0, 9, 32'h99); rd(9); rst = 1'b0; cycle();
        rst = 1'b1;
        rd(9); cycle();
        rd(12); cycle();

        // Random traffic on a narrow address window to force hits and conflicts.
        for (int n = 0; n < 2000; n++) begin
            for (int p = 0; p < 4; p++) begin
                if ($urandom_range(0, 1) == 1) wr(p, $urandom_range(0, 15), $urandom);
            end
            if ($urandom_range(0, 3) != 0) rd($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) rst = 1'b0;
            cycle();
            rst = 1'b1;
        end

        drain = 0;
        while (q_vld.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        if (q_vld.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, expected 0", q_vld.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
